// File: rtl/reg_file_param_if.sv
// Register file port bundle: one write port, two combinational read ports and ready.
// The master drives the write and read addresses; the slave returns read data and ready.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              ready;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, ready
    );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file with reset-driven clear sequencer and optional hardwired-zero entry 0.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic             clk,
    input logic             rst,
    reg_file_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              user_we;
    logic              wr_zero_hit;
    logic              ready_o;

    logic [ADDR_W-1:0] rd_addr_w [2];
    logic [DATA_W-1:0] rd_data_w [2];

    assign wr_zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);

    // State register: reset restarts the clear from entry 0 regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == {ADDR_W{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // The array has a single write port shared by the clearer and the user.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        user_we   = 1'b0;
        ready_o   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = !rst;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
            end
            S_RUN: begin
                ready_o = 1'b1;
                user_we = !rst && bus.wr_en && !wr_zero_hit;
                mem_we  = user_we;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_addr_w[0] = bus.rd_addr1;
    assign rd_addr_w[1] = bus.rd_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            always_comb begin
                data = '0;
                if (state_q == S_RUN) begin
                    if (!((ZERO_REG != 0) && (rd_addr_w[gi] == '0))) begin
                        data = mem_q[rd_addr_w[gi]];
                    end
`ifdef REGFILE_BYPASS_EN
                    // user_we already excludes suppressed writes to entry 0.
                    if (user_we && (bus.wr_addr == rd_addr_w[gi])) begin
                        data = bus.wr_data;
                    end
`endif
                end
            end
            assign rd_data_w[gi] = data;
        end
    endgenerate

    assign bus.rd_data1 = rd_data_w[0];
    assign bus.rd_data2 = rd_data_w[1];
    assign bus.ready    = ready_o;
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build, ZERO_REG=0 copy, and a 64x8 variant.
module tb_reg_file_param;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    reg_file_param_if #(.DATA_W(64), .ADDR_W(3)) bus2 ();

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    reg_file_param #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // The ZERO_REG=0 copy sees exactly the same traffic as the default instance.
    assign bus1.wr_en    = bus0.wr_en;
    assign bus1.wr_addr  = bus0.wr_addr;
    assign bus1.wr_data  = bus0.wr_data;
    assign bus1.rd_addr1 = bus0.rd_addr1;
    assign bus1.rd_addr2 = bus0.rd_addr2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear32(input string tag);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 22 || k == 31) check({tag, "_rdy_lo"}, 64'(bus0.ready), 64'd0);
            if (k == 32)            check({tag, "_rdy_hi"}, 64'(bus0.ready), 64'd1);
        end
    endtask

    logic [31:0] exp_same;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus0.rd_addr1 = '0; bus0.rd_addr2 = '0;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus2.rd_addr1 = '0; bus2.rd_addr2 = '0;

        // Reset state while rst is held.
        tick();
        tick();
        check("rst_ready", 64'(bus0.ready), 64'd0);
        check("rst_rd1", 64'(bus0.rd_data1), 64'd0);
        check("rst_rd2", 64'(bus0.rd_data2), 64'd0);
        check("rst_ready_p", 64'(bus2.ready), 64'd0);

        // Clear sequence with a write attempt to x3 held on throughout.
        rst = 1'b0;
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd3; bus0.wr_data = 32'hAAAA5555;
        bus0.rd_addr1 = 5'd3; bus0.rd_addr2 = 5'd0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32 && (k == 2 || k == 20 || k == 31)) begin
                check("clr_rd1", 64'(bus0.rd_data1), 64'd0);
                check("clr_rd2", 64'(bus0.rd_data2), 64'd0);
            end
            if (k == 31) check("clr_rdy_lo", 64'(bus0.ready), 64'd0);
            if (k == 32) check("clr_rdy_hi", 64'(bus0.ready), 64'd1);
            if (k == 7)  check("p_rdy_lo", 64'(bus2.ready), 64'd0);
            if (k == 8)  check("p_rdy_hi", 64'(bus2.ready), 64'd1);
        end
        bus0.wr_en = 1'b0;
        #1;
        check("clr_x3", 64'(bus0.rd_data1), 64'd0);
        check("clr_x3_nz", 64'(bus1.rd_data1), 64'd0);

        for (int a = 0; a < 32; a++) begin
            bus0.rd_addr1 = 5'(a);
            bus0.rd_addr2 = 5'(31 - a);
            #1;
            check($sformatf("zero_rd1_x%0d", a), 64'(bus0.rd_data1), 64'd0);
            check($sformatf("zero_rd2_x%0d", 31 - a), 64'(bus0.rd_data2), 64'd0);
        end

        // Write x5 and read on the same cycle, then on the next.
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
        bus0.rd_addr1 = 5'd5; bus0.rd_addr2 = 5'd4;
        #1;
        check("wr_same_rd1", 64'(bus0.rd_data1), 64'(exp_same));
        check("wr_same_rd2_other", 64'(bus0.rd_data2), 64'd0);
        tick();
        bus0.wr_en = 1'b0;
        bus0.rd_addr2 = 5'd5;
        #1;
        check("wr_next_rd1", 64'(bus0.rd_data1), 64'hDEADBEEF);
        check("wr_next_rd2", 64'(bus0.rd_data2), 64'hDEADBEEF);

        // Write to x0: ignored with ZERO_REG=1, stored with ZERO_REG=0.
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd0; bus0.wr_data = 32'h12345678;
        bus0.rd_addr1 = 5'd0; bus0.rd_addr2 = 5'd0;
        #1;
        check("x0_same_z", 64'(bus0.rd_data1), 64'd0);
        tick();
        bus0.wr_en = 1'b0;
        #1;
        check("x0_z_rd1", 64'(bus0.rd_data1), 64'd0);
        check("x0_z_rd2", 64'(bus0.rd_data2), 64'd0);
        check("x0_nz_rd1", 64'(bus1.rd_data1), 64'h12345678);
        check("x0_nz_rd2", 64'(bus1.rd_data2), 64'h12345678);

        // 64-bit, 8-entry variant.
        bus2.wr_en = 1'b1; bus2.wr_addr = 3'd7; bus2.wr_data = 64'hFFFF_0000_FFFF_0000;
        tick();
        bus2.wr_addr = 3'd0; bus2.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus2.wr_en = 1'b0;
        bus2.rd_addr1 = 3'd7; bus2.rd_addr2 = 3'd0;
        #1;
        check("p_x7", bus2.rd_data1, 64'hFFFF_0000_FFFF_0000);
        check("p_x0", bus2.rd_data2, 64'd0);

        // Fill x1..x31 with their index, then reset in RUN.
        for (int i = 1; i < 32; i++) begin
            bus0.wr_en = 1'b1; bus0.wr_addr = 5'(i); bus0.wr_data = 32'(i);
            tick();
        end
        bus0.wr_en = 1'b0;
        bus0.rd_addr1 = 5'd7; bus0.rd_addr2 = 5'd31;
        #1;
        check("fill_x7", 64'(bus0.rd_data1), 64'd7);
        check("fill_x31", 64'(bus0.rd_data2), 64'd31);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerun_rdy", 64'(bus0.ready), 64'd0);
        check("rerun_rd1", 64'(bus0.rd_data1), 64'd0);
        wait_clear32("rerun");
        for (int a = 1; a < 32; a++) begin
            bus0.rd_addr1 = 5'(a);
            #1;
            check($sformatf("rerun_x%0d", a), 64'(bus0.rd_data1), 64'd0);
        end

        // Reset reasserted at CLEAR cycle 10 restarts the full clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear32("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the core's register file: generic data width and depth, optional hardwired-zero entry 0, two combinational read ports and one synchronous write port.
- Adds a synchronous reset that runs a self-clearing sequencer over every entry, so the array contents are defined after reset without relying on simulation initialisation.
- Asserts ready once clearing completes.
- Sits in the RV32I decode/writeback path as a drop-in for the integer register file.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes; when 0 entry 0 is an ordinary register.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data, combinational.
- rd_data2  output  DATA_W  read port 2 data, combinational.
- ready  output  1  high when the clear sequence has finished and the file accepts writes.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- State machine has two states, CLEAR and RUN, plus a clear index clr_idx (ADDR_W bits).
- rst sampled high at a clk edge:
  - state <= CLEAR, clr_idx <= 0, ready <= 0.
  - rst dominates every other input.
- CLEAR state:
  - Each cycle, entry[clr_idx] <= 0 and clr_idx <= clr_idx + 1.
  - When clr_idx == DEPTH-1, that entry is cleared and state <= RUN, ready <= 1 on the same edge.
  - Clearing takes exactly DEPTH cycles after rst deasserts (32 cycles at default).
- During CLEAR:
  - wr_en is ignored; no user write reaches the array.
  - rd_data1 and rd_data2 are forced to 0.
- rst reasserted mid-CLEAR restarts the sequence at clr_idx = 0 with full DEPTH-cycle latency.
- rst asserted in RUN discards contents by re-clearing the whole array.
- RUN state:
  - If wr_en && !(ZERO_REG && wr_addr == 0), then entry[wr_addr] <= wr_data at the clk edge.
  - The write is visible on the read ports from the following cycle.
- Reads in RUN:
  - rd_dataN = (ZERO_REG && rd_addrN == 0) ? 0 : entry[rd_addrN].
  - Purely combinational, no latency.
- Both read ports may address the same entry; both return identical data.
- Same-cycle write and read of the same address, without bypass: the read returns the old value.
- ready stays high in RUN until the next rst.
- Reset values: ready = 0; rd_data1 and rd_data2 = 0 from the first cycle of CLEAR onward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In RUN, if wr_en && wr_addr == rd_addrN and the write is not suppressed by ZERO_REG, then rd_dataN = wr_data in the same cycle (write-to-read forwarding).
  - Each read port forwards independently.
  - No forwarding during CLEAR.
  - No forwarding for address 0 when ZERO_REG = 1.
- Undefined: no forwarding; reads return stored contents only, as described under Behaviour.

Test Plan:
- Clear sequence: assert rst 1 cycle, release → ready = 0 for 32 cycles and rises on the 32nd edge after release; every address then reads 0 on both ports.
- Write/read: in RUN write 0xDEADBEEF to x5, then read rd_addr1 = 5 and rd_addr2 = 5 → both return 0xDEADBEEF the next cycle; without the macro, a same-cycle read returns 0; with REGFILE_BYPASS_EN, a same-cycle read returns 0xDEADBEEF.
- Zero register: with ZERO_REG = 1, write 0x12345678 to x0 → rd_data1 = 0 always. With ZERO_REG = 0, the same write → reads 0x12345678.
- Write during CLEAR: assert wr_en with addr 3, data 0xAAAA5555 on cycle 2 of CLEAR → no effect; after ready, x3 reads 0, and rd_data is 0 throughout CLEAR.
- Reset mid-operation:
  - Fill x1..x31 with the index value.
  - Assert rst for 1 cycle in RUN → ready = 0; all entries read 0 after 32 cycles.
  - Reassert rst at CLEAR cycle 10 → ready rises 32 cycles after that release, not 22.
- Parametric: DATA_W = 64, ADDR_W = 3 → clear takes 8 cycles; a write of 0xFFFF_0000_FFFF_0000 to entry 7 reads back intact; entry 0 stays 0.
